input_port_cluster_v2: RTL and testbench

- Single-clock, parametrised successor to the per-port input cluster on the BFT leaf interface.
- Demultiplexes the leaf's incoming packet stream into NUM_IN_PORTS per-port FIFOs, matched on destination port and programmed source leaf/port.
- Presents payloads to the user with valid/ack.
- Returns flow-control credits as round-robin-arbitrated credit packets on a ready/valid output, instead of raw per-port pulses.
- Adds per-port enable, configurable FIFO depth, overflow drop counters and a sticky overflow flag.

---
 rtl/input_port_pkg.sv | 24 ++
 rtl/input_port_fifo.sv | 40 ++++
 rtl/input_port_cluster_v2.sv | 131 +++++++++++++
 tb/tb_input_port_cluster_v2.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_port_pkg.sv
// input_port_pkg: packet field layout helpers and credit arbiter state encoding
package input_port_pkg;
    typedef enum logic {IDLE, SEND} arb_state_t;

    function automatic int pkt_bits(input int leaf_bits, input int port_bits, input int payload_bits);
        return 1 + 2 * (leaf_bits + port_bits) + payload_bits;
    endfunction

    function automatic int src_port_lsb(input int payload_bits);
        return payload_bits;
    endfunction

    function automatic int src_leaf_lsb(input int port_bits, input int payload_bits);
        return payload_bits + port_bits;
    endfunction

    function automatic int dst_port_lsb(input int leaf_bits, input int port_bits, input int payload_bits);
        return payload_bits + port_bits + leaf_bits;
    endfunction

    function automatic int dst_leaf_lsb(input int leaf_bits, input int port_bits, input int payload_bits);
        return payload_bits + 2 * port_bits + leaf_bits;
    endfunction
endpackage

// File: rtl/input_port_fifo.sv
// input_port_fifo: single-clock first-word-fall-through FIFO, push accepted when full if a pop occurs
module input_port_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH_BITS = 7
) (
    input  logic             clk_bft,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             vld,
    output logic             full
);
    logic [WIDTH-1:0] mem [2**DEPTH_BITS];
    logic [DEPTH_BITS-1:0] rd_ptr, wr_ptr;
    logic [DEPTH_BITS:0] count;
    logic push_ok, pop_ok;

    assign vld = count != '0;
    assign full = count[DEPTH_BITS];
    assign pop_ok = pop && vld;
    assign push_ok = push && (!full || pop_ok);
    // memory is not reset, so the head is masked while empty
    assign dout = vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_bft)
        if (push_ok) mem[wr_ptr] <= din;

    always_ff @(posedge clk_bft or negedge reset)
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
            if (pop_ok) rd_ptr <= rd_ptr + DEPTH_BITS'(1);
            count <= count + (DEPTH_BITS + 1)'(push_ok) - (DEPTH_BITS + 1)'(pop_ok);
        end
endmodule

// File: rtl/input_port_cluster_v2.sv
// input_port_cluster_v2: demuxes leaf packets into per-port FIFOs and returns
// freed space as round-robin arbitrated credit packets
module input_port_cluster_v2
    import input_port_pkg::*;
#(
    parameter int NUM_LEAF_BITS = 6,
    parameter int NUM_PORT_BITS = 4,
    parameter int PAYLOAD_BITS = 64,
    parameter int NUM_IN_PORTS = 7,
    parameter int PORT_BASE = 2,
    parameter int FIFO_DEPTH_BITS = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int DROP_CNT_BITS = 16
) (
    input  logic                                                     clk_bft,
    input  logic                                                     reset,
    input  logic [pkt_bits(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS)-1:0] stream_in,
    input  logic [NUM_LEAF_BITS-1:0]                                 self_leaf,
    input  logic [(NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_IN_PORTS-1:0]    in_control_reg,
    input  logic [NUM_IN_PORTS-1:0]                                  in_enable,
    output logic [pkt_bits(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS)-1:0] credit_out_pkt,
    output logic                                                     credit_out_vld,
    input  logic                                                     credit_out_rdy,
    output logic [PAYLOAD_BITS*NUM_IN_PORTS-1:0]                     dout2user,
    output logic [NUM_IN_PORTS-1:0]                                  vld2user,
    input  logic [NUM_IN_PORTS-1:0]                                  ack_user2b_in,
    output logic [DROP_CNT_BITS*NUM_IN_PORTS-1:0]                    drop_count,
    output logic [NUM_IN_PORTS-1:0]                                  overflow
);
    localparam int PKT_BITS = pkt_bits(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int VALID_POS = PKT_BITS - 1;
    localparam int DST_LEAF_LSB = dst_leaf_lsb(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int DST_PORT_LSB = dst_port_lsb(NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int SRC_LEAF_LSB = src_leaf_lsb(NUM_PORT_BITS, PAYLOAD_BITS);
    localparam int SRC_PORT_LSB = src_port_lsb(PAYLOAD_BITS);
    localparam int CFG_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int PEND_BITS = FIFO_DEPTH_BITS + 1;
    localparam int PTR_BITS = NUM_IN_PORTS > 1 ? $clog2(NUM_IN_PORTS) : 1;
    localparam logic [PEND_BITS-1:0] FUS = PEND_BITS'(FREESPACE_UPDATE_SIZE);

    logic pkt_valid;
    logic [NUM_PORT_BITS-1:0] dst_port, src_port;
    logic [NUM_LEAF_BITS-1:0] src_leaf;
    logic unused_dst_leaf;
    logic [NUM_LEAF_BITS-1:0] cfg_leaf [NUM_IN_PORTS];
    logic [NUM_PORT_BITS-1:0] cfg_port [NUM_IN_PORTS];
    logic [NUM_IN_PORTS-1:0] match, pop, drop, full, req;
    arb_state_t state;
    logic [PTR_BITS-1:0] rr, sel, pick;
    logic credit_done;

    assign pkt_valid = stream_in[VALID_POS];
    assign dst_port = stream_in[DST_PORT_LSB +: NUM_PORT_BITS];
    assign src_leaf = stream_in[SRC_LEAF_LSB +: NUM_LEAF_BITS];
    assign src_port = stream_in[SRC_PORT_LSB +: NUM_PORT_BITS];
    // destination leaf is guaranteed by upstream routing
    assign unused_dst_leaf = ^stream_in[DST_LEAF_LSB +: NUM_LEAF_BITS];
    assign credit_done = credit_out_vld && credit_out_rdy;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_ch
        localparam logic [NUM_PORT_BITS-1:0] PORT_ID = NUM_PORT_BITS'(PORT_BASE + i);
        logic [DROP_CNT_BITS-1:0] cnt;
        logic [PEND_BITS-1:0] pend;
        logic ovf;

        assign {cfg_leaf[i], cfg_port[i]} = in_control_reg[i*CFG_BITS +: CFG_BITS];
        assign match[i] = pkt_valid && dst_port == PORT_ID && src_leaf == cfg_leaf[i]
                          && src_port == cfg_port[i] && in_enable[i];
        assign pop[i] = vld2user[i] && ack_user2b_in[i];
        assign drop[i] = match[i] && full[i] && !pop[i];
        assign req[i] = pend >= FUS;
        assign overflow[i] = ovf;
        assign drop_count[i*DROP_CNT_BITS +: DROP_CNT_BITS] = cnt;

        input_port_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
            .clk_bft(clk_bft),
            .reset(reset),
            .push(match[i]),
            .din(stream_in[PAYLOAD_BITS-1:0]),
            .pop(ack_user2b_in[i]),
            .dout(dout2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .vld(vld2user[i]),
            .full(full[i])
        );

        always_ff @(posedge clk_bft or negedge reset)
            if (!reset) begin
                cnt <= '0;
                ovf <= 1'b0;
                pend <= '0;
            end else begin
                if (drop[i] && cnt != '1) cnt <= cnt + DROP_CNT_BITS'(1);
                if (drop[i]) ovf <= 1'b1;
                pend <= pend + PEND_BITS'(pop[i]) - (credit_done && sel == PTR_BITS'(i) ? FUS : '0);
            end
    end

    // scan downwards so the requester closest at-or-after rr wins
    always_comb begin
        int j;
        j = 0;
        pick = rr;
        for (int k = NUM_IN_PORTS - 1; k >= 0; k--) begin
            j = int'(rr) + k;
            j = j >= NUM_IN_PORTS ? j - NUM_IN_PORTS : j;
            pick = req[j] ? PTR_BITS'(j) : pick;
        end
    end

    always_ff @(posedge clk_bft or negedge reset)
        if (!reset) begin
            state <= IDLE;
            sel <= '0;
            rr <= '0;
            credit_out_vld <= 1'b0;
            credit_out_pkt <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                state <= SEND;
                sel <= pick;
                credit_out_vld <= 1'b1;
                credit_out_pkt <= {1'b1, cfg_leaf[pick], cfg_port[pick], self_leaf,
                                   NUM_PORT_BITS'(PORT_BASE + int'(pick)),
                                   PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};
            end
        end else if (credit_out_rdy) begin
            state <= IDLE;
            credit_out_vld <= 1'b0;
            rr <= sel == PTR_BITS'(NUM_IN_PORTS - 1) ? '0 : sel + PTR_BITS'(1);
        end
endmodule

// File: tb/tb_input_port_cluster_v2.sv
// tb_input_port_cluster_v2: directed bench with per-channel payload scoreboard
module tb_input_port_cluster_v2;
    localparam int LB = 6, PB = 4, DB = 64, N = 7, BASE = 2, DEPTH = 128, FUS = 64, DCB = 16;
    localparam int PKT = 1 + 2 * (LB + PB) + DB;

    logic clk_bft = 1'b0;
    logic reset = 1'b0;
    logic [PKT-1:0] stream_in, credit_out_pkt;
    logic [LB-1:0] self_leaf;
    logic [(LB+PB)*N-1:0] in_control_reg;
    logic [N-1:0] in_enable, vld2user, ack, overflow;
    logic credit_out_vld, credit_out_rdy;
    logic [DB*N-1:0] dout2user;
    logic [DCB*N-1:0] drop_count;

    logic [LB-1:0] cfg_leaf [N];
    logic [PB-1:0] cfg_port [N];
    logic [DB-1:0] q [N][$];
    int drops [N];
    logic [N-1:0] ovf_m;
    int passed = 0, failed = 0, total = 0;

    always #5 clk_bft = ~clk_bft;

    input_port_cluster_v2 #(
        .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PB), .PAYLOAD_BITS(DB), .NUM_IN_PORTS(N),
        .PORT_BASE(BASE), .FIFO_DEPTH_BITS(7), .FREESPACE_UPDATE_SIZE(FUS), .DROP_CNT_BITS(DCB)
    ) dut (
        .clk_bft(clk_bft),
        .reset(reset),
        .stream_in(stream_in),
        .self_leaf(self_leaf),
        .in_control_reg(in_control_reg),
        .in_enable(in_enable),
        .credit_out_pkt(credit_out_pkt),
        .credit_out_vld(credit_out_vld),
        .credit_out_rdy(credit_out_rdy),
        .dout2user(dout2user),
        .vld2user(vld2user),
        .ack_user2b_in(ack),
        .drop_count(drop_count),
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PKT-1:0] mk(input int port, input int leaf, input int sport, input logic [DB-1:0] pl);
        return {1'b1, LB'(0), PB'(port), LB'(leaf), PB'(sport), pl};
    endfunction

    function automatic logic [PKT-1:0] cred(input int c);
        return {1'b1, cfg_leaf[c], cfg_port[c], self_leaf, PB'(BASE + c), DB'(FUS)};
    endfunction

    // model one clock: compare heads being popped, queue matching pushes, track drops
    task automatic tick();
        int pre;
        bit popm, m;
        logic [N-1:0] exp_v;
        for (int c = 0; c < N; c++) begin
            pre = q[c].size();
            popm = ack[c] && pre > 0;
            if (popm) begin
                chk($sformatf("dout_ch%0d", c), dout2user[c*DB +: DB], q[c][0]);
                void'(q[c].pop_front());
            end
            m = stream_in[PKT-1] && stream_in[DB+PB+LB +: PB] == PB'(BASE + c)
                && stream_in[DB+PB +: LB] == cfg_leaf[c] && stream_in[DB +: PB] == cfg_port[c] && in_enable[c];
            if (m) begin
                if (pre < DEPTH || popm) q[c].push_back(stream_in[DB-1:0]);
                else begin
                    if (drops[c] < 65535) drops[c]++;
                    ovf_m[c] = 1'b1;
                end
            end
        end
        @(posedge clk_bft);
        #1;
        for (int c = 0; c < N; c++) exp_v[c] = q[c].size() > 0;
        chk("vld2user", vld2user, exp_v);
    endtask

    task automatic chk_stats();
        for (int c = 0; c < N; c++) chk($sformatf("drop_ch%0d", c), drop_count[c*DCB +: DCB], drops[c]);
        chk("overflow", overflow, ovf_m);
    endtask

    task automatic round(input int a, input int b, input int f, input int s);
        ack = '0;
        credit_out_rdy = 1'b1;
        for (int i = 0; i < FUS; i++) begin
            stream_in = mk(BASE + a, cfg_leaf[a], cfg_port[a], DB'(i + 'h300));
            tick();
            stream_in = mk(BASE + b, cfg_leaf[b], cfg_port[b], DB'(i + 'h400));
            tick();
        end
        stream_in = '0;
        ack[a] = 1'b1;
        ack[b] = 1'b1;
        repeat (FUS) tick();
        ack = '0;
        chk("rr_pre_vld", credit_out_vld, 0);
        tick();
        chk("rr_first_vld", credit_out_vld, 1);
        chk("rr_first_pkt", credit_out_pkt, cred(f));
        tick();
        chk("rr_gap_vld", credit_out_vld, 0);
        tick();
        chk("rr_second_vld", credit_out_vld, 1);
        chk("rr_second_pkt", credit_out_pkt, cred(s));
        tick();
        chk("rr_done_vld", credit_out_vld, 0);
    endtask

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        stream_in = '0;
        ack = '0;
        credit_out_rdy = 1'b1;
        self_leaf = 6'd33;
        in_enable = '1;
        ovf_m = '0;
        cfg_leaf = '{6'd1, 6'd5, 6'd7, 6'd9, 6'd13, 6'd14, 6'd11};
        cfg_port = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd6};
        for (int c = 0; c < N; c++) begin
            drops[c] = 0;
            in_control_reg[c*(LB+PB) +: LB+PB] = {cfg_leaf[c], cfg_port[c]};
        end
        repeat (3) @(posedge clk_bft);
        #1;
        reset = 1'b1;
        chk("rst_vld2user", vld2user, 0);
        chk("rst_dout", |dout2user, 0);
        chk("rst_credit_vld", credit_out_vld, 0);
        chk("rst_credit_pkt", credit_out_pkt, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_overflow", overflow, 0);

        // single delivery to ch1
        stream_in = mk(3, 5, 2, 64'hA5);
        tick();
        stream_in = '0;
        chk("ch1_dout", dout2user[DB +: DB], 64'hA5);
        ack = 7'b0000010;
        tick();
        ack = '0;

        // mismatched source, then matching but disabled
        stream_in = mk(3, 6, 2, 64'h11);
        tick();
        in_enable[1] = 1'b0;
        stream_in = mk(3, 5, 2, 64'h22);
        tick();
        in_enable = '1;
        stream_in = '0;
        tick();
        chk_stats();

        // overflow on ch0, then push alongside pop while full
        for (int i = 0; i < DEPTH; i++) begin
            stream_in = mk(2, 1, 1, DB'(i));
            tick();
        end
        repeat (3) begin
            stream_in = mk(2, 1, 1, 64'hDEAD);
            tick();
        end
        stream_in = '0;
        chk("ch0_drop3", drop_count[DCB-1:0], 3);
        chk("ch0_ovf", overflow[0], 1);
        chk_stats();
        stream_in = mk(2, 1, 1, 64'h1000);
        ack[0] = 1'b1;
        tick();
        ack = '0;
        stream_in = mk(2, 1, 1, 64'h2000);
        tick();
        stream_in = '0;
        chk("ch0_drop4", drop_count[DCB-1:0], 4);
        ack[0] = 1'b1;
        repeat (DEPTH) tick();
        ack = '0;
        repeat (5) tick();
        chk("ch0_credits_idle", credit_out_vld, 0);
        chk_stats();

        // ch2 credit with back-pressure
        credit_out_rdy = 1'b0;
        for (int i = 0; i < FUS; i++) begin
            stream_in = mk(4, 7, 3, DB'(i + 'h200));
            tick();
        end
        stream_in = '0;
        ack[2] = 1'b1;
        repeat (FUS) tick();
        ack = '0;
        chk("ch2_credit_early", credit_out_vld, 0);
        tick();
        chk("ch2_credit_vld", credit_out_vld, 1);
        chk("ch2_credit_pkt", credit_out_pkt, {1'b1, 6'd7, 4'd3, 6'd33, 4'd4, 64'd64});
        repeat (5) begin
            tick();
            chk("ch2_hold_vld", credit_out_vld, 1);
            chk("ch2_hold_pkt", credit_out_pkt, {1'b1, 6'd7, 4'd3, 6'd33, 4'd4, 64'd64});
        end
        credit_out_rdy = 1'b1;
        tick();
        chk("ch2_after_hs", credit_out_vld, 0);
        repeat (3) tick();
        chk("ch2_pend_cleared", credit_out_vld, 0);

        // reset in the middle of traffic with a credit outstanding
        credit_out_rdy = 1'b0;
        for (int i = 0; i < FUS; i++) begin
            stream_in = mk(2, 1, 1, DB'(i + 'h500));
            tick();
        end
        for (int i = 0; i < FUS; i++) begin
            stream_in = mk(3, 5, 2, DB'(i + 'h600));
            tick();
        end
        stream_in = '0;
        ack[1] = 1'b1;
        repeat (FUS) tick();
        ack = '0;
        tick();
        chk("pre_rst_credit", credit_out_vld, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_vld2user", vld2user, 0);
        chk("mid_rst_dout", |dout2user, 0);
        chk("mid_rst_credit_vld", credit_out_vld, 0);
        chk("mid_rst_credit_pkt", credit_out_pkt, 0);
        chk("mid_rst_drop", drop_count, 0);
        chk("mid_rst_overflow", overflow, 0);
        for (int c = 0; c < N; c++) begin
            q[c].delete();
            drops[c] = 0;
        end
        ovf_m = '0;
        @(posedge clk_bft);
        #1;
        reset = 1'b1;
        credit_out_rdy = 1'b1;
        stream_in = mk(3, 5, 2, 64'hBEEF);
        tick();
        stream_in = '0;
        chk("post_rst_dout", dout2user[DB +: DB], 64'hBEEF);
        ack[1] = 1'b1;
        tick();
        ack = '0;
        repeat (3) tick();
        chk("post_rst_no_credit", credit_out_vld, 0);

        // round-robin ties: pointer 0 then wrap from 4
        round(0, 3, 0, 3);
        round(3, 6, 6, 3);
        chk_stats();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
